// File: rtl/lfsr_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_ctrl
//
// Sequence generator built around a 4-bit LFSR. A run is requested with
// start while idle; the controller then streams `len` LFSR values over a
// valid/ready handshake. The first value emitted is the loaded seed, and
// every accepted transfer advances the LFSR once.
//
// Optional feature (macro LFSR_CTRL_PERIOD_CHK_EN):
//   When defined, the loaded value is kept in a register. A sticky `wrap`
//   flag rises in the cycle after any LFSR step whose result equals that
//   loaded value. When undefined, `wrap` is tied low and neither the
//   register nor the comparator is built. The port list is the same in both
//   builds.
//
// Parameters:
//   LEN_W       width of len; the longest run is 2^LEN_W-1 values
//
// Ports:
//   clk         sole clock; all state changes on its rising edge
//   rst         synchronous active-high reset; has priority over everything
//   start       run request, sampled only in IDLE
//   seed[3:0]   initial LFSR value, captured when start is accepted
//   len         number of values to emit, captured when start is accepted
//   abort       ends the run early; acted on only in RUN
//   out_valid   out_data is valid (high throughout RUN)
//   out_ready   sink accepts out_data this cycle
//   out_data    current LFSR state (visible in every state)
//   busy        high whenever the FSM is not in IDLE
//   done        one-cycle pulse when a run completes normally
//   seed_fixed  the most recently captured seed was 0000 and was replaced
//   wrap        LFSR returned to the loaded value (period-check builds only)
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for start; out_valid low
//   RUN   | streaming values; out_valid high
//   DONE  | single cycle with done high, then back to IDLE
// ---------------------------------------------------------------------------
module lfsr_ctrl #(
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       seed,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             busy,
  output logic             done,
  output logic             seed_fixed,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [3:0]       lfsr;
  logic [3:0]       lfsr_step;
  logic [3:0]       seed_eff;
  logic [LEN_W-1:0] remain;
  logic             seed_fixed_q;

  logic             accept;
  logic             load;
  logic             xfer;
  logic             step_en;
  logic             last_xfer;

  // An all-zero state would lock the LFSR up, so a zero seed becomes 1111.
  assign seed_eff = (seed == 4'b0000) ? 4'b1111 : seed;

  // q0'=q3, q1'=q0^q3, q2'=q1, q3'=q2^q3
  assign lfsr_step = {lfsr[2] ^ lfsr[3], lfsr[1], lfsr[0] ^ lfsr[3], lfsr[3]};

  // ---------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    load      = 1'b0;
    xfer      = 1'b0;
    step_en   = 1'b0;
    last_xfer = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (len == '0) begin
            state_nxt = DONE;
          end else begin
            load      = 1'b1;
            state_nxt = RUN;
          end
        end
      end

      RUN: begin
        xfer      = out_ready;
        last_xfer = out_ready && (remain == LEN_W'(1));
        // A transfer that coincides with abort is counted as consumed,
        // but the LFSR holds so out_data keeps showing that value.
        step_en   = out_ready && !abort;
        if (abort) begin
          state_nxt = IDLE;
        end else if (last_xfer) begin
          state_nxt = DONE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State register and datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lfsr         <= 4'b0000;
      remain       <= '0;
      seed_fixed_q <= 1'b0;
    end else begin
      state <= state_nxt;

      if (load) begin
        lfsr   <= seed_eff;
        remain <= len;
      end else begin
        if (xfer) begin
          remain <= remain - LEN_W'(1);
        end
        if (step_en) begin
          lfsr <= lfsr_step;
        end
      end

      // Zero-length requests still count as an accept for this flag.
      if (accept) begin
        seed_fixed_q <= (seed == 4'b0000);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Period check
  // ---------------------------------------------------------------------
`ifdef LFSR_CTRL_PERIOD_CHK_EN
  logic [3:0] ref_val;
  logic       wrap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_val <= 4'b0000;
      wrap_q  <= 1'b0;
    end else begin
      if (load) begin
        ref_val <= seed_eff;
      end
      if (accept) begin
        wrap_q <= 1'b0;
      end else if (step_en && (lfsr_step == ref_val)) begin
        wrap_q <= 1'b1;
      end
    end
  end

  assign wrap = wrap_q;
`else
  assign wrap = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign out_valid  = (state == RUN);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign out_data   = lfsr;
  assign seed_fixed = seed_fixed_q;

endmodule

// File: tb/tb_lfsr_ctrl.sv
module tb_lfsr_ctrl;

  localparam int LEN_W = 6;

  logic             clk;
  logic             rst;
  logic             start;
  logic [3:0]       seed;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_data;
  logic             busy;
  logic             done;
  logic             seed_fixed;
  logic             wrap;

  lfsr_ctrl #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .len        (len),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .seed_fixed (seed_fixed),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;

  // Scoreboard: values the sink should see, in order.
  logic [3:0] sb_q[$];

  // Reference model state.
  logic [3:0] cur_val  = 4'b0000;
  logic [3:0] loaded   = 4'b0000;
  logic       sf_exp   = 1'b0;
  logic       wrap_exp = 1'b0;

`ifdef LFSR_CTRL_PERIOD_CHK_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  function automatic logic [3:0] step(input logic [3:0] q);
    logic [3:0] n;
    n[0] = q[3];
    n[1] = q[0] ^ q[3];
    n[2] = q[1];
    n[3] = q[2] ^ q[3];
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one start..DONE..IDLE sequence. ready_mode 0: always ready,
  // 1: ready pattern 1,0,0 repeating. hold_start keeps start asserted
  // (with seed 0, len 0) during the run to show it is ignored.
  task automatic run_stream(input logic [3:0] s, input logic [LEN_W-1:0] l,
                            input int ready_mode, input bit hold_start,
                            input string name);
    logic [3:0] v;
    int         cyc;
    int         nxfer;
    bit         x;
    start = 1'b1;
    seed  = s;
    len   = l;
    sf_exp   = (s == 4'b0000);
    wrap_exp = 1'b0;
    if (l != 0) begin
      v       = (s == 4'b0000) ? 4'b1111 : s;
      loaded  = v;
      cur_val = v;
      for (int i = 0; i < int'(l); i++) begin
        sb_q.push_back(v);
        v = step(v);
      end
    end
    tick();
    if (hold_start) begin
      seed = 4'b0000;
      len  = '0;
    end else begin
      start = 1'b0;
    end
    cyc   = 0;
    nxfer = 0;
    while (sb_q.size() != 0 && cyc < 200) begin
      out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (out_valid !== 1'b1) begin
        $display("FAIL %s valid: got %b want 1 (cyc %0d)", name, out_valid, cyc);
        errors++;
      end
      checks++;
      if (out_data !== sb_q[0]) begin
        $display("FAIL %s data: got %h want %h (cyc %0d)", name, out_data, sb_q[0], cyc);
        errors++;
      end
      checks++;
      if (wrap !== (WRAP_EN & wrap_exp)) begin
        $display("FAIL %s wrap: got %b want %b (cyc %0d)", name, wrap, WRAP_EN & wrap_exp, cyc);
        errors++;
      end
      checks++;
      x = out_ready;
      tick();
      if (x) begin
        void'(sb_q.pop_front());
        nxfer++;
        cur_val = step(cur_val);
        if (cur_val == loaded) wrap_exp = 1'b1;
      end
      cyc++;
    end
    if (sb_q.size() != 0) begin
      $display("FAIL %s timeout: got %0d values left want 0", name, sb_q.size());
      errors++;
      sb_q.delete();
    end
    checks++;
    start     = 1'b0;
    out_ready = 1'b0;
    if (nxfer != int'(l)) begin
      $display("FAIL %s count: got %0d transfers want %0d", name, nxfer, l);
      errors++;
    end
    checks++;
    if ({done, busy, out_valid} !== 3'b110) begin
      $display("FAIL %s done cycle: got done/busy/valid %b want 110", name, {done, busy, out_valid});
      errors++;
    end
    checks++;
    if (out_data !== cur_val || seed_fixed !== sf_exp) begin
      $display("FAIL %s end state: got data %h sf %b want %h %b", name, out_data, seed_fixed, cur_val, sf_exp);
      errors++;
    end
    checks++;
    tick();
    if ({done, busy, out_valid} !== 3'b000) begin
      $display("FAIL %s idle after done: got done/busy/valid %b want 000", name, {done, busy, out_valid});
      errors++;
    end
    checks++;
    if (wrap !== (WRAP_EN & wrap_exp)) begin
      $display("FAIL %s wrap end: got %b want %b", name, wrap, WRAP_EN & wrap_exp);
      errors++;
    end
    checks++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    if ({out_valid, busy, done, seed_fixed, wrap} !== 5'b00000 || out_data !== 4'b0000) begin
      $display("FAIL reset: got v/b/d/sf/w %b data %h want 00000 0", {out_valid, busy, done, seed_fixed, wrap}, out_data);
      errors++;
    end
    checks++;
  endtask

  task automatic test_basic();
    run_stream(4'b0001, 6'd3, 0, 1'b1, "basic");
  endtask

  task automatic test_seed_fix();
    run_stream(4'b0000, 6'd2, 0, 1'b0, "seed_fix");
  endtask

  task automatic test_stall();
    run_stream(4'b1000, 6'd4, 1, 1'b0, "stall");
  endtask

  task automatic test_back_to_back();
    run_stream(4'b0101, 6'd3, 0, 1'b0, "b2b_a");
    run_stream(4'b1001, 6'd5, 1, 1'b0, "b2b_b");
  endtask

  task automatic test_wrap();
    run_stream(4'b0001, 6'd8, 0, 1'b0, "wrap");
  endtask

  task automatic test_abort();
    logic [3:0] v;
    start = 1'b1;
    seed  = 4'b0110;
    len   = 6'd10;
    sf_exp   = 1'b0;
    wrap_exp = 1'b0;
    loaded   = 4'b0110;
    v        = 4'b0110;
    tick();
    start     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (out_data !== v || out_valid !== 1'b1) begin
        $display("FAIL abort pre %0d: got %h/%b want %h/1", i, out_data, out_valid, v);
        errors++;
      end
      checks++;
      tick();
      v = step(v);
      if (v == loaded) wrap_exp = 1'b1;
    end
    abort = 1'b1;
    tick();
    abort     = 1'b0;
    out_ready = 1'b0;
    cur_val   = v;
    if ({out_valid, busy, done} !== 3'b000) begin
      $display("FAIL abort exit: got v/b/d %b want 000", {out_valid, busy, done});
      errors++;
    end
    checks++;
    if (out_data !== v) begin
      $display("FAIL abort hold: got %h want %h", out_data, v);
      errors++;
    end
    checks++;
    tick();
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL abort no done: got done %b busy %b want 0 0", done, busy);
      errors++;
    end
    checks++;
  endtask

  task automatic test_rst_mid();
    start = 1'b1;
    seed  = 4'b0000;
    len   = 6'd5;
    tick();
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    rst   = 1'b1;
    start = 1'b1;
    abort = 1'b1;
    seed  = 4'b0011;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    cur_val  = 4'b0000;
    sf_exp   = 1'b0;
    wrap_exp = 1'b0;
    if ({out_valid, busy, done, seed_fixed, wrap} !== 5'b00000 || out_data !== 4'b0000) begin
      $display("FAIL rst_mid: got v/b/d/sf/w %b data %h want 00000 0", {out_valid, busy, done, seed_fixed, wrap}, out_data);
      errors++;
    end
    checks++;
    tick();
    if (busy !== 1'b0) begin
      $display("FAIL rst_priority: got busy %b want 0", busy);
      errors++;
    end
    checks++;
  endtask

  task automatic test_len_zero();
    start = 1'b1;
    seed  = 4'b1010;
    len   = '0;
    sf_exp   = 1'b0;
    wrap_exp = 1'b0;
    tick();
    // Now in DONE: a fresh request here must be ignored.
    seed = 4'b0000;
    len  = 6'd7;
    if ({done, busy, out_valid} !== 3'b110) begin
      $display("FAIL len0 done: got done/busy/valid %b want 110", {done, busy, out_valid});
      errors++;
    end
    checks++;
    if (out_data !== cur_val || seed_fixed !== sf_exp) begin
      $display("FAIL len0 state: got data %h sf %b want %h %b", out_data, seed_fixed, cur_val, sf_exp);
      errors++;
    end
    checks++;
    tick();
    start = 1'b0;
    if ({done, busy, out_valid} !== 3'b000 || seed_fixed !== 1'b0) begin
      $display("FAIL len0 idle: got done/busy/valid %b sf %b want 000 0", {done, busy, out_valid}, seed_fixed);
      errors++;
    end
    checks++;
    tick();
    if (busy !== 1'b0) begin
      $display("FAIL start_in_done: got busy %b want 0", busy);
      errors++;
    end
    checks++;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    seed      = 4'b0000;
    len       = '0;
    abort     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_seed_fix();
    test_stall();
    test_back_to_back();
    test_abort();
    test_rst_mid();
    test_len_zero();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
